// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes, states,
// ALUOp / PCSource / ALUSrcB codes and the packed control word.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctrl_t;

  // DECODE dispatch; unsupported opcodes fall back to FETCH.
  function automatic state_e decode_next(logic [5:0] op, logic addi_en);
    state_e nxt;
    nxt = ST_FETCH;
    case (op)
      OP_LW, OP_SW: nxt = ST_MEMADR;
      OP_RTYPE:     nxt = ST_EXEC;
      OP_BEQ:       nxt = ST_BRANCH;
      OP_J:         nxt = ST_JUMP;
      OP_ADDI:      nxt = addi_en ? ST_ADDIEX : ST_FETCH;
      default:      nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic op_supported(logic [5:0] op, logic addi_en);
    return (decode_next(op, addi_en) != ST_FETCH);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, state,
           instr_done, illegal_op
  );

  modport slave (
    output opcode,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, state,
           instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_control_outdecode.sv
// Moore output decode: maps the FSM state to the datapath control word.
module mips_multicycle_control_outdecode
  import mips_multicycle_control_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.ior_d      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// opcode-driven next-state logic and reset gating of the write enables.
//
// state  | meaning
// FETCH  | read instruction, IR <= mem[PC], PC <= PC + 4
// DECODE | read registers, ALUOut <= branch target, dispatch on opcode
// MEMADR | ALUOut <= A + signext(imm) for lw/sw
// MEMRD  | MDR <= mem[ALUOut]
// MEMWB  | rt <= MDR (lw done)
// MEMWR  | mem[ALUOut] <= B (sw done)
// EXEC   | ALUOut <= A op B using funct
// ALUWB  | rd <= ALUOut (R-type done)
// BRANCH | compare A/B, PC <= ALUOut if zero (beq done)
// JUMP   | PC <= jump target (j done)
// ADDIEX | ALUOut <= A + signext(imm)
// ADDIWB | rt <= ALUOut (addi done)
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int ENABLE_ADDI = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_multicycle_control_if.master    bus
);

  localparam logic ADDI_EN = (ENABLE_ADDI != 0);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = decode_next(bus.opcode, ADDI_EN);
      // Opcode is taken live from the IR here rather than latched in DECODE.
      ST_MEMADR: state_d = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  assign illegal_raw = (state_q == ST_DECODE) && !op_supported(bus.opcode, ADDI_EN);

  mips_multicycle_control_outdecode u_outdecode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Side-effecting strobes are held low for the whole reset window.
  assign bus.PCWrite     = ctrl.pc_write      & ~reset;
  assign bus.PCWriteCond = ctrl.pc_write_cond & ~reset;
  assign bus.IRWrite     = ctrl.ir_write      & ~reset;
  assign bus.MemRead     = ctrl.mem_read      & ~reset;
  assign bus.MemWrite    = ctrl.mem_write     & ~reset;
  assign bus.RegWrite    = ctrl.reg_write     & ~reset;
  assign bus.instr_done  = ctrl.instr_done    & ~reset;
  assign bus.illegal_op  = illegal_raw        & ~reset;

  assign bus.IorD     = ctrl.ior_d;
  assign bus.MemtoReg = ctrl.mem_to_reg;
  assign bus.PCSource = ctrl.pc_source;
  assign bus.ALUOp    = ctrl.alu_op;
  assign bus.ALUSrcA  = ctrl.alu_src_a;
  assign bus.ALUSrcB  = ctrl.alu_src_b;
  assign bus.RegDst   = ctrl.reg_dst;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-instruction state
// sequences and per-state control words checked against a spec-level model.
module tb_mips_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset1, reset0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if bus1 ();
  mips_multicycle_control_if bus0 ();

  mips_multicycle_control #(.ENABLE_ADDI(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  mips_multicycle_control #(.ENABLE_ADDI(0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst,instr_done}
  wire [16:0] obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                      bus1.MemtoReg, bus1.IRWrite, bus1.PCSource, bus1.ALUOp, bus1.ALUSrcA,
                      bus1.ALUSrcB, bus1.RegWrite, bus1.RegDst, bus1.instr_done};
  wire [7:0] we1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IRWrite, bus1.MemRead,
                    bus1.MemWrite, bus1.RegWrite, bus1.instr_done, bus1.illegal_op};

  // Control word each state must present, transcribed from the state descriptions.
  function automatic logic [16:0] exp_ctrl(int s);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, done;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, done} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iord = 1; done = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      10: begin srca = 1; srcb = 2'b10; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srca, srcb, rw, rd, done};
  endfunction

  function automatic bit is_legal(logic [5:0] op, bit addi_en);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP) ||
           ((op == ADDI) && addi_en);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction on dut1 starting from a FETCH sample point; ends at the next FETCH.
  task automatic run_instr(input logic [5:0] op, input string tag);
    int q[$];
    bit ill;
    bus1.opcode = op;
    #1;
    ill = !is_legal(op, 1'b1);
    q = '{0, 1};
    case (op)
      LW:   begin q.push_back(2); q.push_back(3); q.push_back(4); end
      SW:   begin q.push_back(2); q.push_back(5); end
      RT:   begin q.push_back(6); q.push_back(7); end
      BEQ:  q.push_back(8);
      JMP:  q.push_back(9);
      ADDI: begin q.push_back(10); q.push_back(11); end
      default: ;
    endcase
    foreach (q[i]) begin
      if (i > 0) step();
      n_tests++;
      if (bus1.state !== 4'(q[i])) begin
        n_fail++;
        $display("FAIL %s state[%0d]: got %0d expected %0d", tag, i, bus1.state, q[i]);
      end
      n_tests++;
      if (obs1 !== exp_ctrl(q[i])) begin
        n_fail++;
        $display("FAIL %s ctrl[%0d]: got %h expected %h", tag, i, obs1, exp_ctrl(q[i]));
      end
      n_tests++;
      if (bus1.illegal_op !== (ill && q[i] == 1)) begin
        n_fail++;
        $display("FAIL %s illegal_op[%0d]: got %b expected %b", tag, i, bus1.illegal_op, ill && q[i] == 1);
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset1 = 1'b1;
    bus1.opcode = LW;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (bus1.state !== 4'd0 || we1 !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: state %0d enables %b expected state 0 enables 00000000", c, bus1.state, we1);
      end
    end
    reset1 = 1'b0;
    run_instr(LW, "lw_after_reset");
  endtask

  task automatic test_back_to_back();
    run_instr(RT, "rtype");
    run_instr(SW, "sw");
  endtask

  task automatic test_branch();
    run_instr(BEQ, "beq");
  endtask

  task automatic test_jump_addi();
    run_instr(JMP, "j");
    run_instr(ADDI, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, "illegal_3f");
    run_instr(6'b001101, "illegal_ori");
    n_tests++;
    if (bus1.illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse_len: got %b expected 0", bus1.illegal_op);
    end
  endtask

  task automatic test_addi_disabled();
    int exp_st[3] = '{0, 1, 0};
    bus0.opcode = ADDI;
    reset0 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_tests++;
      if (bus0.state !== 4'(exp_st[i]) || bus0.illegal_op !== (i == 1) ||
          bus0.RegWrite !== 1'b0 || bus0.MemWrite !== 1'b0) begin
        n_fail++;
        $display("FAIL addi_disabled[%0d]: state %0d ill %b rw %b mw %b expected state %0d ill %b rw 0 mw 0",
                 i, bus0.state, bus0.illegal_op, bus0.RegWrite, bus0.MemWrite, exp_st[i], i == 1);
      end
    end
    bus0.opcode = RT;
    step();
    step();
    n_tests++;
    if (bus0.state !== 4'd6 || bus0.illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_disabled_rtype: state %0d ill %b expected 6 0", bus0.state, bus0.illegal_op);
    end
  endtask

  task automatic test_reset_mid_lw();
    bus1.opcode = LW;
    #1;
    step(); step(); step();
    n_tests++;
    if (bus1.state !== 4'd3) begin
      n_fail++;
      $display("FAIL midlw_reach_memrd: got %0d expected 3", bus1.state);
    end
    reset1 = 1'b1;
    #1;
    n_tests++;
    if (bus1.MemRead !== 1'b0 || bus1.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midlw_gate: MemRead %b RegWrite %b expected 0 0", bus1.MemRead, bus1.RegWrite);
    end
    step();
    n_tests++;
    if (bus1.state !== 4'd0 || bus1.RegWrite !== 1'b0 || we1 !== 8'h00) begin
      n_fail++;
      $display("FAIL midlw_abort: state %0d enables %b expected 0 00000000", bus1.state, we1);
    end
    reset1 = 1'b0;
    run_instr(JMP, "j_after_abort");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = JMP;
        5: op = ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op, 1'b1)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, $sformatf("rand%0d_op%02h", k, op));
    end
  endtask

  initial begin
    reset1 = 1'b1;
    reset0 = 1'b1;
    bus1.opcode = 6'b0;
    bus0.opcode = 6'b0;
    test_reset();
    test_back_to_back();
    test_branch();
    test_jump_addi();
    test_illegal();
    test_addi_disabled();
    test_reset_mid_lw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
